pawn_move_scanner: RTL and testbench
====================================

PAWN_MOVE_SCANNER -- requirements
Module: pawn_move_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; forces all state to reset values at the next clk edge.
REQ-004 start  input  1  one-cycle request to scan the board; sampled only in IDLE.
REQ-005 color  input  1  side to scan: 0 = white, 1 = black; captured on accepted start.
REQ-006 pawnMap  input  64  bit i = 1 when square i holds a pawn of the scanned side; captured on accepted start.
REQ-007 pos  output  6  square index presented to the pawn evaluator.
REQ-008 colorPawn  output  1  captured color presented to the pawn evaluator.
REQ-009 allow  input  3  combinational evaluator answer for (pos, colorPawn): bit0 = one-square advance, bit1 = two-square advance, bit2 = one-square advance promotes.
REQ-010 moveValid  output  1  move record available.
REQ-011 moveReady  input  1  consumer accepts the record when moveValid & moveReady at a clk edge.
REQ-012 moveFrom  output  6  origin square.
REQ-013 moveTo  output  6  destination square.
REQ-014 movePromo  output  1  record is a promoting move.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse at scan completion.
REQ-017 moveCount  output  5  records accepted in current/last scan, 0..16.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN, EMIT1, EMIT2, DONE.
REQ-019 IDLE: start=1 -> capture color and pawnMap, clear idx to 0 and moveCount to 0, go to SCAN; busy=1 from the next cycle.
REQ-020 start while not in IDLE SHALL be ignored.
REQ-021 pos SHALL equal idx and colorPawn the captured color at all times.
REQ-022 SCAN, one square per cycle: if captured pawnMap[idx]=0 or allow[1:0]=00 -> advance idx.
REQ-023 SCAN, pawnMap[idx]=1 and allow[0]=1 -> register allow, go to EMIT1; else if allow[1]=1 -> register allow, go to EMIT2.
REQ-024 Advancing from idx=63 SHALL go to DONE instead of wrapping.
REQ-025 EMIT1: moveValid=1, moveFrom=idx, moveTo=idx+8 (white) or idx-8 (black), movePromo=registered allow[2].
REQ-026 EMIT1 on handshake: increment moveCount; go to EMIT2 if registered allow[1]=1, else advance idx (or DONE at 63) and return to SCAN.
REQ-027 EMIT2: moveValid=1, moveFrom=idx, moveTo=idx+16 (white) or idx-16 (black), movePromo=0.
REQ-028 EMIT2 on handshake: increment moveCount, advance idx (or DONE at 63), return to SCAN.
REQ-029 While moveValid=1 and moveReady=0, moveFrom, moveTo, movePromo SHALL hold stable.
REQ-030 moveValid SHALL be 0 outside EMIT1/EMIT2; the record fields are don't-care there.
REQ-031 moveTo arithmetic SHALL be 6-bit modulo; out-of-board targets are not checked (the evaluator does not set allow for them).
REQ-032 moveCount SHALL saturate at 16 and hold its value after DONE until the next accepted start.
REQ-033 DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-034 Scan latency with no moves SHALL be 64 SCAN cycles + 1 DONE cycle after the start edge.

Reset
REQ-035 On reset: state=IDLE, idx=0, pos=0, colorPawn=0, moveValid=0, moveFrom=0, moveTo=0, movePromo=0, busy=0, done=0, moveCount=0.
REQ-036 Reset mid-scan or mid-handshake SHALL abort: no further records or done pulse; a record pending on that edge is not counted.

Verification
REQ-037 Empty map: start, color=0, pawnMap=0 -> no moveValid, done pulses 65 cycles after the start edge, moveCount=0.
REQ-038 White pawn sq 8, evaluator allow=011, moveReady=1 -> records (8->16, promo 0) then (8->24, promo 0); moveCount=2.
REQ-039 Black pawn sq 8, allow=101 -> one record 8->0, movePromo=1; moveCount=1.
REQ-040 Backpressure: white pawn sq 12, allow=001, moveReady=0 for 5 cycles -> moveValid held with 12->20 stable, accepted on cycle 6, scan resumes at sq 13.
REQ-041 Full rank: white pawns sq 8..15, all allow=011 -> 16 records in ascending origin order, moveCount=16, single done pulse.
REQ-042 Reset asserted during EMIT1 -> next cycle state IDLE, all outputs at reset values; start issued while busy is ignored.

Source files
------------

// File: rtl/pawn_move_scanner.sv
// rtl/pawn_move_scanner.sv - scans a 64-square pawn map and streams legal pawn advances
// One square is evaluated per cycle; each allowed advance is emitted as a valid/ready record.
module pawn_move_scanner (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        color_i,
    input  logic [63:0] pawnMap_i,
    output logic [5:0]  pos_o,
    output logic        colorPawn_o,
    input  logic [2:0]  allow_i,
    output logic        moveValid_o,
    input  logic        moveReady_i,
    output logic [5:0]  moveFrom_o,
    output logic [5:0]  moveTo_o,
    output logic        movePromo_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  moveCount_o
);

    typedef enum logic [2:0] {IDLE, SCAN, EMIT1, EMIT2, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        color_q, color_d;
    logic [63:0] map_q, map_d;
    logic        promo_q, promo_d;
    logic        two_q, two_d;
    logic [4:0]  count_q, count_d;

    logic        last_sq;
    logic [4:0]  count_inc;

    assign last_sq   = (idx_q == 6'd63);
    assign count_inc = (count_q == 5'd16) ? count_q : count_q + 5'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= 6'd0;
            color_q <= 1'b0;
            map_q   <= 64'd0;
            promo_q <= 1'b0;
            two_q   <= 1'b0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            map_q   <= map_d;
            promo_q <= promo_d;
            two_q   <= two_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        color_d     = color_q;
        map_d       = map_q;
        promo_d     = promo_q;
        two_d       = two_q;
        count_d     = count_q;
        moveValid_o = 1'b0;
        moveFrom_o  = 6'd0;
        moveTo_o    = 6'd0;
        movePromo_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    color_d = color_i;
                    map_d   = pawnMap_i;
                    idx_d   = 6'd0;
                    count_d = 5'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (map_q[idx_q] && allow_i[0]) begin
                    promo_d = allow_i[2];
                    two_d   = allow_i[1];
                    state_d = EMIT1;
                end else if (map_q[idx_q] && allow_i[1]) begin
                    promo_d = allow_i[2];
                    two_d   = allow_i[1];
                    state_d = EMIT2;
                end else if (last_sq) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            EMIT1: begin
                moveValid_o = 1'b1;
                moveFrom_o  = idx_q;
                moveTo_o    = color_q ? idx_q - 6'd8 : idx_q + 6'd8;
                movePromo_o = promo_q;
                if (moveReady_i) begin
                    count_d = count_inc;
                    if (two_q) begin
                        state_d = EMIT2;
                    end else if (last_sq) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = SCAN;
                    end
                end
            end
            EMIT2: begin
                moveValid_o = 1'b1;
                moveFrom_o  = idx_q;
                moveTo_o    = color_q ? idx_q - 6'd16 : idx_q + 6'd16;
                if (moveReady_i) begin
                    count_d = count_inc;
                    if (last_sq) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pos_o       = idx_q;
    assign colorPawn_o = color_q;
    assign busy_o      = (state_q == SCAN) || (state_q == EMIT1) || (state_q == EMIT2);
    assign done_o      = (state_q == DONE);
    assign moveCount_o = count_q;

endmodule

// File: tb/tb_pawn_move_scanner.sv
// tb/tb_pawn_move_scanner.sv - self-checking bench for pawn_move_scanner
module tb_pawn_move_scanner;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        color_i;
    logic [63:0] pawnMap_i;
    logic [5:0]  pos_o;
    logic        colorPawn_o;
    logic [2:0]  allow_i;
    logic        moveValid_o;
    logic        moveReady_i;
    logic [5:0]  moveFrom_o;
    logic [5:0]  moveTo_o;
    logic        movePromo_o;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  moveCount_o;

    int checks   = 0;
    int failures = 0;

    // Evaluator stand-in: per-square answer table looked up by the presented square.
    logic [2:0] tab [64];

    typedef struct {
        logic [5:0] from;
        logic [5:0] to;
        logic       promo;
    } rec_t;

    always #5 clk_i = ~clk_i;

    always_comb allow_i = tab[pos_o];

    pawn_move_scanner dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .color_i     (color_i),
        .pawnMap_i   (pawnMap_i),
        .pos_o       (pos_o),
        .colorPawn_o (colorPawn_o),
        .allow_i     (allow_i),
        .moveValid_o (moveValid_o),
        .moveReady_i (moveReady_i),
        .moveFrom_o  (moveFrom_o),
        .moveTo_o    (moveTo_o),
        .movePromo_o (movePromo_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .moveCount_o (moveCount_o)
    );

    task automatic clear_tab();
        for (int i = 0; i < 64; i++) tab[i] = 3'b000;
    endtask

    // Runs one full scan: model predicts the record list, DUT output is consumed with random readiness.
    task automatic run_scan(input logic c, input logic [63:0] m, input int rdy_pct,
                            input string name, output int latency);
        rec_t exp_q[$];
        rec_t r, held;
        int   exp_cnt, n;
        bit   done_seen, hold;
        exp_q = {};
        for (int i = 0; i < 64; i++) begin
            if (m[i]) begin
                if (tab[i][0]) begin
                    r.from = 6'(i);
                    r.to = 6'(c ? (i + 64 - 8) % 64 : (i + 8) % 64);
                    r.promo = tab[i][2];
                    exp_q.push_back(r);
                end
                if (tab[i][1]) begin
                    r.from = 6'(i);
                    r.to = 6'(c ? (i + 64 - 16) % 64 : (i + 16) % 64);
                    r.promo = 1'b0;
                    exp_q.push_back(r);
                end
            end
        end
        exp_cnt = (exp_q.size() > 16) ? 16 : exp_q.size();

        @(negedge clk_i);
        start_i = 1'b1; color_i = c; pawnMap_i = m;
        @(negedge clk_i);
        start_i = 1'b0; pawnMap_i = ~m; color_i = ~c;
        n = 1; done_seen = 0; hold = 0;
        held = '{from: 6'd0, to: 6'd0, promo: 1'b0};
        while (!done_seen && n < 3000) begin
            if (done_o) begin
                done_seen = 1;
                checks++;
                if (busy_o !== 1'b0 || moveValid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_cycle busy=%0b valid=%0b required 0/0", name, busy_o, moveValid_o);
                end
            end else begin
                checks++;
                if (busy_o !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy cycle=%0d got=%0b required 1", name, n, busy_o);
                end
                if (moveValid_o === 1'b1) begin
                    if (hold) begin
                        checks++;
                        if (moveFrom_o !== held.from || moveTo_o !== held.to || movePromo_o !== held.promo) begin
                            failures++;
                            $display("FAIL %s stable got=%0d->%0d p%0b required %0d->%0d p%0b", name,
                                     moveFrom_o, moveTo_o, movePromo_o, held.from, held.to, held.promo);
                        end
                    end
                    moveReady_i = ($urandom_range(99) < rdy_pct);
                    if (moveReady_i) begin
                        hold = 0;
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL %s extra_record got=%0d->%0d required none", name, moveFrom_o, moveTo_o);
                        end else begin
                            r = exp_q.pop_front();
                            if (moveFrom_o !== r.from || moveTo_o !== r.to || movePromo_o !== r.promo) begin
                                failures++;
                                $display("FAIL %s record got=%0d->%0d p%0b required %0d->%0d p%0b", name,
                                         moveFrom_o, moveTo_o, movePromo_o, r.from, r.to, r.promo);
                            end
                        end
                    end else begin
                        hold = 1;
                        held.from = moveFrom_o; held.to = moveTo_o; held.promo = movePromo_o;
                    end
                end else begin
                    if (hold) begin
                        checks++;
                        failures++;
                        $display("FAIL %s valid_dropped got=0 required 1", name);
                    end
                    hold = 0;
                    moveReady_i = $urandom_range(1);
                end
            end
            if (!done_seen) begin
                @(negedge clk_i);
                n++;
            end
        end
        latency = n;
        moveReady_i = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s done_timeout got=none required pulse", name);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_records got=%0d left required 0", name, exp_q.size());
        end
        checks++;
        if (moveCount_o !== 5'(exp_cnt)) begin
            failures++;
            $display("FAIL %s moveCount got=%0d required %0d", name, moveCount_o, exp_cnt);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || moveCount_o !== 5'(exp_cnt)) begin
            failures++;
            $display("FAIL %s after_done done=%0b busy=%0b cnt=%0d required 0/0/%0d", name,
                     done_o, busy_o, moveCount_o, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start_i = 1'b0; color_i = 1'b0; pawnMap_i = '0; moveReady_i = 1'b0;
        clear_tab();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        checks++;
        if ({pos_o, colorPawn_o, moveValid_o, moveFrom_o, moveTo_o, movePromo_o, busy_o, done_o, moveCount_o} !== '0) begin
            failures++;
            $display("FAIL reset_state got pos=%0d col=%0b v=%0b f=%0d t=%0d p=%0b busy=%0b done=%0b cnt=%0d required all 0",
                     pos_o, colorPawn_o, moveValid_o, moveFrom_o, moveTo_o, movePromo_o, busy_o, done_o, moveCount_o);
        end
    endtask

    task automatic test_empty();
        int lat;
        clear_tab();
        run_scan(1'b0, 64'd0, 100, "empty", lat);
        checks++;
        if (lat != 65) begin
            failures++;
            $display("FAIL empty_latency got=%0d required 65", lat);
        end
    endtask

    task automatic test_white_double();
        int lat;
        clear_tab();
        tab[8] = 3'b011;
        run_scan(1'b0, 64'd1 << 8, 100, "white_sq8", lat);
    endtask

    task automatic test_black_promo();
        int lat;
        clear_tab();
        tab[8] = 3'b101;
        run_scan(1'b1, 64'd1 << 8, 100, "black_sq8", lat);
    endtask

    task automatic test_backpressure();
        int n;
        clear_tab();
        tab[12] = 3'b001;
        @(negedge clk_i);
        start_i = 1'b1; color_i = 1'b0; pawnMap_i = 64'd1 << 12; moveReady_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (moveValid_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (moveValid_o !== 1'b1 || moveFrom_o !== 6'd12 || moveTo_o !== 6'd20 || movePromo_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got v=%0b %0d->%0d p%0b required 1 12->20 p0",
                         k, moveValid_o, moveFrom_o, moveTo_o, movePromo_o);
            end
            moveReady_i = (k == 5);
            @(negedge clk_i);
        end
        moveReady_i = 1'b0;
        checks++;
        if (moveValid_o !== 1'b0 || pos_o !== 6'd13 || moveCount_o !== 5'd1) begin
            failures++;
            $display("FAIL bp_resume got v=%0b pos=%0d cnt=%0d required 0/13/1", moveValid_o, pos_o, moveCount_o);
        end
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1 || moveCount_o !== 5'd1) begin
            failures++;
            $display("FAIL bp_done got done=%0b cnt=%0d required 1/1", done_o, moveCount_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_full_rank();
        int lat;
        clear_tab();
        for (int i = 8; i < 16; i++) tab[i] = 3'b011;
        run_scan(1'b0, 64'h0000_0000_0000_FF00, 100, "full_rank", lat);
    endtask

    task automatic test_saturate();
        int lat;
        clear_tab();
        for (int i = 8; i < 24; i++) tab[i] = 3'b011;
        run_scan(1'b0, 64'h0000_0000_00FF_FF00, 70, "saturate", lat);
    endtask

    task automatic test_random();
        int lat;
        logic [63:0] m;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 64; i++) tab[i] = 3'($urandom_range(7));
            m = {$urandom, $urandom} & {$urandom, $urandom};
            run_scan(1'($urandom_range(1)), m, 60, "random", lat);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_tab();
        tab[20] = 3'b001;
        @(negedge clk_i);
        start_i = 1'b1; color_i = 1'b0; pawnMap_i = 64'd1 << 20; moveReady_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        start_i = 1'b1; color_i = 1'b1; pawnMap_i = '1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (moveValid_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (moveValid_o !== 1'b1 || moveFrom_o !== 6'd20 || moveTo_o !== 6'd28 || colorPawn_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_ignored got v=%0b %0d->%0d col=%0b required 1 20->28 col0",
                     moveValid_o, moveFrom_o, moveTo_o, colorPawn_o);
        end
        moveReady_i = 1'b1; reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0; moveReady_i = 1'b0;
        checks++;
        if ({pos_o, colorPawn_o, moveValid_o, moveFrom_o, moveTo_o, movePromo_o, busy_o, done_o, moveCount_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid got pos=%0d v=%0b busy=%0b done=%0b cnt=%0d required all 0",
                     pos_o, moveValid_o, busy_o, done_o, moveCount_o);
        end
        n = 0;
        for (int k = 0; k < 70; k++) begin
            if (moveValid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL reset_abort activity_cycles got=%0d required 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_white_double();
        test_black_promo();
        test_backpressure();
        test_full_rank();
        test_saturate();
        test_random();
        test_reset_mid();
        test_white_double();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
